divider_ctrl: RTL and testbench



---
 rtl/divider_ctrl_pkg.sv | 31 +++
 rtl/divider_ctrl_tick_counter.sv | 33 +++
 rtl/divider_ctrl.sv | 121 ++++++++++++
 tb/tb_divider_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_ctrl_pkg.sv
// Shared types for the clock-divide controller.
//   mode_e  : config request mode as carried on cfg_mode
//   state_e : controller operating state
//   cfg_is_valid() : acceptance rule for a config request
package divider_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_STOP  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_BURST = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BURST
  } state_e;

  // STOP ignores the divisor/count fields; RUN needs div >= 2;
  // BURST additionally needs a non-zero count; reserved mode is never valid.
  function automatic logic cfg_is_valid(mode_e mode, logic div_ok, logic count_ok);
    logic ok;
    ok = 1'b0;
    if (mode == MODE_STOP)       ok = 1'b1;
    else if (mode == MODE_RUN)   ok = div_ok;
    else if (mode == MODE_BURST) ok = div_ok && count_ok;
    return ok;
  endfunction

endpackage

// File: rtl/divider_ctrl_tick_counter.sv
// Loadable modulo-N counter.
//   clk, rst : clock, asynchronous active-low reset
//   load     : clear the count to 0 (priority over en)
//   en       : advance the count
//   n        : modulus (>= 2); count runs 0..n-1 and wraps
//   tc       : terminal count, high while en and count == n-1
module tick_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] n,
  output logic             tc
);

  logic [WIDTH-1:0] cnt;

  // n >= 2 is guaranteed by the controller, so n-1 never wraps.
  assign tc = en && (cnt == n - WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/divider_ctrl.sv
// Runtime controller for the clock-divide path.
// Holds the divisor, takes new settings over a valid/ready config port and
// produces a 1-cycle tick enable plus a glitch-free 50% divided clock.
//   clk, rst           : clock, asynchronous active-low reset
//   cfg_valid/ready    : config handshake (transfer when both high)
//   cfg_mode           : 00 STOP, 01 RUN, 10 BURST, 11 reserved
//   cfg_div, cfg_count : divisor, BURST length in clk_div periods
//   tick, clk_div      : divider outputs
//   busy, done, err    : status (done/err are 1-cycle pulses)
module divider_ctrl
  import divider_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_mode,
  input  logic [WIDTH-1:0]     cfg_div,
  input  logic [CNT_WIDTH-1:0] cfg_count,
  output logic                 tick,
  output logic                 clk_div,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_e               state;
  logic [WIDTH-1:0]     div_reg;
  logic                 pend;
  mode_e                pend_mode;
  logic [WIDTH-1:0]     pend_div;
  logic [CNT_WIDTH-1:0] pend_count;
  logic [CNT_WIDTH:0]   remaining;

  mode_e req_mode;
  logic  req_ok;
  logic  xfer;
  logic  start;
  logic  apply;

  assign req_mode  = mode_e'(cfg_mode);
  assign req_ok    = cfg_is_valid(req_mode, cfg_div >= WIDTH'(2), cfg_count != '0);
  // pend can only be set while running, so this also covers "ready in IDLE".
  assign cfg_ready = !pend;
  assign xfer      = cfg_valid && cfg_ready;
  assign busy      = (state != ST_IDLE);
  assign start     = (state == ST_IDLE) && xfer && req_ok && (req_mode != MODE_STOP);
  // Shadow config only lands on the tick that takes clk_div from 1 to 0.
  assign apply     = tick && clk_div && pend;

  tick_counter #(.WIDTH(WIDTH)) u_tick_counter (
    .clk  (clk),
    .rst  (rst),
    .load (start || apply),
    .en   (busy),
    .n    (div_reg),
    .tc   (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      div_reg    <= WIDTH'(DEFAULT_DIV);
      clk_div    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pend       <= 1'b0;
      pend_mode  <= MODE_STOP;
      pend_div   <= '0;
      pend_count <= '0;
      remaining  <= '0;
    end else begin
      done <= 1'b0;
      err  <= xfer && !req_ok;
      if (state == ST_IDLE) begin
        if (xfer && req_ok) begin
          if (req_mode == MODE_STOP) begin
            done <= 1'b1;
          end else begin
            div_reg   <= cfg_div;
            remaining <= {cfg_count, 1'b0};
            state     <= (req_mode == MODE_BURST) ? ST_BURST : ST_RUN;
          end
        end
      end else begin
        if (xfer && req_ok) begin
          pend       <= 1'b1;
          pend_mode  <= req_mode;
          pend_div   <= cfg_div;
          pend_count <= cfg_count;
        end
        if (tick) begin
          clk_div <= !clk_div;
          if (state == ST_BURST) remaining <= remaining - 1'b1;
          // A pending config takes precedence over the end of a burst; both
          // happen only on a falling clk_div edge, so the output stays clean.
          if (apply) begin
            pend    <= 1'b0;
            clk_div <= 1'b0;
            if (pend_mode == MODE_STOP) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              div_reg   <= pend_div;
              remaining <= {pend_count, 1'b0};
              state     <= (pend_mode == MODE_BURST) ? ST_BURST : ST_RUN;
            end
          end else if (state == ST_BURST && remaining == {{CNT_WIDTH{1'b0}}, 1'b1}) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl: directed scenarios with literal
// expectations, then randomized config traffic, all checked every cycle
// against a cycle-count based reference model.
module tb_divider_ctrl;

  localparam int unsigned W    = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned DDIV = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_mode = 2'b00;
  logic [W-1:0]  cfg_div = '0;
  logic [CW-1:0] cfg_count = '0;
  logic          cfg_ready, tick, clk_div, busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divider_ctrl #(.WIDTH(W), .CNT_WIDTH(CW), .DEFAULT_DIV(DDIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
    .cfg_count (cfg_count),
    .tick      (tick),
    .clk_div   (clk_div),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endfunction

  // Reference model: ticks fall on every cycle whose index since the last
  // load is a multiple of the divisor; level flips per tick; ticks_left counts
  // down a burst; a pending request is held until a falling-level tick.
  int          m_state;   // 0 idle, 1 run, 2 burst
  int unsigned m_div, m_k, m_left;
  bit          m_lvl, m_pend, m_done, m_err;
  int          p_mode;
  int unsigned p_div, p_cnt;

  function automatic bit ref_valid(int mode, int unsigned div, int unsigned cnt);
    if (mode == 3) return 1'b0;
    if (mode == 0) return 1'b1;
    if (div < 2) return 1'b0;
    if (mode == 2 && cnt == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_start(int mode, int unsigned div, int unsigned cnt);
    m_state = mode;
    m_div   = div;
    m_k     = 1;
    m_left  = 2 * cnt;
    m_lvl   = 1'b0;
  endfunction

  function automatic void model_step(bit t);
    bit xfer, ok, apply;
    xfer   = cfg_valid && !m_pend;
    ok     = ref_valid(int'(cfg_mode), cfg_div, cfg_count);
    m_done = 1'b0;
    m_err  = xfer && !ok;
    if (m_state == 0) begin
      if (xfer && ok) begin
        if (cfg_mode == 2'b00) m_done = 1'b1;
        else m_start(int'(cfg_mode), cfg_div, cfg_count);
      end
    end else begin
      apply = t && m_lvl && m_pend;
      if (xfer && ok) begin
        m_pend = 1'b1;
        p_mode = int'(cfg_mode);
        p_div  = cfg_div;
        p_cnt  = cfg_count;
      end
      m_k++;
      if (t) begin
        m_lvl = !m_lvl;
        if (m_state == 2) m_left--;
      end
      if (apply) begin
        m_pend = 1'b0;
        m_lvl  = 1'b0;
        if (p_mode == 0) begin
          m_state = 0;
          m_done  = 1'b1;
        end else begin
          m_start(p_mode, p_div, p_cnt);
        end
      end else if (t && m_state == 2 && m_left == 0) begin
        m_state = 0;
        m_done  = 1'b1;
      end
    end
  endfunction

  always @(negedge clk) begin
    bit e_tick;
    if (!rst) begin
      m_state = 0; m_pend = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_lvl = 1'b0; m_div = DDIV; m_k = 0; m_left = 0;
      chk("rst_tick", tick, 0);
      chk("rst_clk_div", clk_div, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
    end else begin
      e_tick = (m_state != 0) && (m_k % m_div == 0);
      chk("tick", tick, e_tick);
      chk("clk_div", clk_div, m_lvl);
      chk("busy", busy, m_state != 0);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("cfg_ready", cfg_ready, !m_pend);
      model_step(e_tick);
    end
  end

  task automatic send(input logic [1:0] mode, input int unsigned div, input int unsigned cnt);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    cfg_mode  = mode;
    cfg_div   = W'(div);
    cfg_count = CW'(cnt);
    cfg_valid = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("send_ready_timeout", got, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    chk("idle_timeout", got, 1);
  endtask

  task automatic stop_all();
    send(2'b00, 0, 0);
    wait_idle();
  endtask

  int burst_ticks;
  bit acc;

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("init_ready", cfg_ready, 1);
    chk("init_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // RUN div=2: ticks in cycles 2 and 4, clk_div high in cycles 3..4
    send(2'b01, 2, 0);
    @(negedge clk); chk("a_tick_c1", tick, 0);
    @(negedge clk); chk("a_tick_c2", tick, 1); chk("a_busy", busy, 1); chk("a_clk_c2", clk_div, 0);
    @(negedge clk); chk("a_clk_c3", clk_div, 1); chk("a_tick_c3", tick, 0);
    @(negedge clk); chk("a_tick_c4", tick, 1);
    @(negedge clk); chk("a_clk_c5", clk_div, 0);
    stop_all();

    // RUN div=4, then RUN div=3 transferred in cycle 6 (clk_div high)
    send(2'b01, 4, 0);
    repeat (5) @(negedge clk);
    send(2'b01, 3, 0);
    @(negedge clk); chk("b_ready_c7", cfg_ready, 0);
    @(negedge clk); chk("b_ready_c8", cfg_ready, 0); chk("b_tick_c8", tick, 1); chk("b_clk_c8", clk_div, 1);
    @(negedge clk); chk("b_ready_c9", cfg_ready, 1); chk("b_clk_c9", clk_div, 0);
    @(negedge clk); chk("b_tick_c10", tick, 0);
    @(negedge clk); chk("b_tick_c11", tick, 1);
    @(negedge clk); chk("b_clk_c12", clk_div, 1);
    stop_all();

    // BURST div=2 count=3: six ticks, done one cycle after the last
    send(2'b10, 2, 3);
    burst_ticks = 0;
    repeat (12) begin
      @(negedge clk);
      if (tick) burst_ticks++;
    end
    chk("c_burst_ticks", burst_ticks, 6);
    @(negedge clk);
    chk("c_done", done, 1); chk("c_busy", busy, 0); chk("c_clk_end", clk_div, 0);
    @(negedge clk); chk("c_done_pulse", done, 0);

    // Invalid configs in IDLE, then STOP in IDLE
    send(2'b01, 1, 0);
    @(negedge clk); chk("d_err_div1", err, 1); chk("d_busy1", busy, 0);
    send(2'b01, 0, 0);
    @(negedge clk); chk("d_err_div0", err, 1);
    send(2'b10, 4, 0);
    @(negedge clk); chk("d_err_cnt0", err, 1); chk("d_busy2", busy, 0);
    send(2'b11, 4, 1);
    @(negedge clk); chk("d_err_mode3", err, 1);
    send(2'b00, 0, 0);
    @(negedge clk); chk("d_stop_idle_done", done, 1); chk("d_stop_idle_err", err, 0);

    // RUN div=5, STOP transferred in cycle 3: stops after the cycle-10 tick
    send(2'b01, 5, 0);
    repeat (2) @(negedge clk);
    send(2'b00, 0, 0);
    @(negedge clk); chk("e_ready_c4", cfg_ready, 0);
    repeat (6) @(negedge clk);
    chk("e_tick_c10", tick, 1); chk("e_busy_c10", busy, 1); chk("e_clk_c10", clk_div, 1);
    @(negedge clk);
    chk("e_busy_c11", busy, 0); chk("e_done_c11", done, 1); chk("e_clk_c11", clk_div, 0);
    send(2'b01, 2, 0);
    @(negedge clk); chk("e_restart_busy", busy, 1);
    stop_all();

    // Reset mid-BURST with a pending RUN
    send(2'b10, 4, 5);
    repeat (3) @(negedge clk);
    send(2'b01, 3, 0);
    chk("f_pend", cfg_ready, 0);
    #1 rst = 1'b0;
    #1;
    chk("f_rst_tick", tick, 0); chk("f_rst_clk", clk_div, 0); chk("f_rst_busy", busy, 0);
    chk("f_rst_done", done, 0); chk("f_rst_err", err, 0); chk("f_rst_ready", cfg_ready, 1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("f_pend_lost", busy, 0);

    // Randomized traffic; request fields are held while waiting for ready
    acc = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      @(posedge clk); #1;
      if (!cfg_valid || acc) begin
        cfg_valid = ($urandom_range(0, 3) == 0);
        r = $urandom_range(0, 9);
        cfg_mode = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r < 8) ? 2'b00 : 2'b11;
        r = $urandom_range(0, 29);
        cfg_div = (r == 0) ? W'(0) : (r == 1) ? W'(1) : (r == 2) ? W'(255) :
                  (r == 3) ? W'(254) : W'($urandom_range(2, 6));
        r = $urandom_range(0, 9);
        cfg_count = (r == 0) ? CW'(0) : (r == 1) ? CW'(15) : CW'($urandom_range(1, 4));
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
      end
      @(negedge clk);
      acc = cfg_valid && cfg_ready;
    end
    @(posedge clk); #1 cfg_valid = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
